// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder: FSM state encoding,
// default word width, underrun word and bit-counter width.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  localparam int SPI_DATA_W        = 8;
  localparam int SPI_UNDERRUN_WORD = 0;
  localparam int SPI_CNT_W         = $clog2(SPI_DATA_W + 1);

  // Counter must be able to hold the value DATA_W itself, not just DATA_W-1.
  function automatic int spi_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall detection
// against one extra delayed copy of the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_p0;
  logic              dly_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= {STAGES{RESET_VAL}};
      dly_p1  <= RESET_VAL;
    end else begin
      sync_p0 <= {sync_p0[STAGES-2:0], din};
      dly_p1  <= sync_p0[STAGES-1];
    end
  end

  assign level = sync_p0[STAGES-1];
  assign rise  = level & ~dly_p1;
  assign fall  = ~level & dly_p1;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder: oversampled pins, MOSI deserialiser, MISO serialiser
// with a one-word TX holding register. Define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting.
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int                DATA_W        = SPI_DATA_W,
  parameter int                SYNC_STAGES   = 2,
  parameter logic [DATA_W-1:0] UNDERRUN_WORD = DATA_W'(SPI_UNDERRUN_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int              CNT_W    = spi_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              reload_pend;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  logic              do_load, do_shift, do_capture, do_rx_done, do_abort;
  logic              tx_hs;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_next;
  logic              first_bit, next_bit;

  // Pin synchronisers: CS_N idles high, SCLK and MOSI idle low
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mosi),
    .level (mosi_s),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};

  // An empty holding register is signalled by tx_ready itself
  assign tx_hs     = tx_valid & tx_ready;
  assign load_word = tx_ready ? UNDERRUN_WORD : hold;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign first_bit  = load_word[0];
  assign next_bit   = tx_shift[1];
  assign tx_shifted = {1'b0, tx_shift[DATA_W-1:1]};
  assign rx_next    = {mosi_s, rx_shift[DATA_W-1:1]};
`else
  assign first_bit  = load_word[DATA_W-1];
  assign next_bit   = tx_shift[DATA_W-2];
  assign tx_shifted = {tx_shift[DATA_W-2:0], 1'b0};
  assign rx_next    = {rx_shift[DATA_W-2:0], mosi_s};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_nxt = LOAD;
        LOAD:    state_nxt = SHIFT;
        SHIFT:   state_nxt = SHIFT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A completed word takes priority; the following SCLK fall reloads instead of shifting
  always_comb begin
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_capture = 1'b0;
    do_rx_done = 1'b0;
    do_abort   = cs_rise;
    if (!cs_rise) begin
      case (state)
        LOAD: do_load = 1'b1;
        SHIFT: begin
          if (cnt == CNT_FULL) begin
            do_rx_done = 1'b1;
          end else if (sclk_rise && !cs_lvl) begin
            do_capture = 1'b1;
          end else if (sclk_fall && !cs_lvl) begin
            if (reload_pend) do_load  = 1'b1;
            else             do_shift = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      reload_pend <= 1'b0;
      busy        <= 1'b0;
      miso_oe     <= 1'b0;
      miso        <= 1'b0;
      tx_ready    <= 1'b1;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_data     <= '0;
    end else begin
      rx_valid    <= do_rx_done;
      tx_underrun <= do_load & tx_ready;
      if (tx_hs) begin
        tx_ready <= 1'b0;
      end else if (do_load && !tx_ready) begin
        tx_ready <= 1'b1;
      end
      if (do_abort) begin
        cnt         <= '0;
        reload_pend <= 1'b0;
        busy        <= 1'b0;
        miso_oe     <= 1'b0;
        miso        <= 1'b0;
      end else begin
        if (do_load) begin
          cnt         <= '0;
          reload_pend <= 1'b0;
          busy        <= 1'b1;
          miso_oe     <= 1'b1;
          miso        <= first_bit;
        end
        if (do_shift)   miso <= next_bit;
        if (do_capture) cnt  <= cnt + CNT_W'(1);
        if (do_rx_done) begin
          cnt         <= '0;
          reload_pend <= 1'b1;
          rx_data     <= rx_shift;
        end
      end
    end
  end

  // Datapath registers: fully overwritten before use, so left without reset
  always_ff @(posedge clk) begin
    if (tx_hs) hold <= tx_data;
    if (do_load) begin
      tx_shift <= load_word;
    end else if (do_shift) begin
      tx_shift <= tx_shifted;
    end
    if (do_capture) rx_shift <= rx_next;
  end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: a mode-0 SPI master at SCLK = CLK/8 plus a
// word-level model of the TX holding register and the expected wire order.
module tb_spi_slave_rx_tx;

  localparam int         DW = 8;
  localparam int         SS = 2;
  localparam logic [7:0] UW = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n, sclk, cs_n, mosi;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data, rx_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rxv_cnt  = 0;
  int und_cnt  = 0;
  int rxv_cyc  = 0;
  int last_rise_cyc = 0;
  logic [7:0] rxq[$];

  bit         hold_full = 1'b0;
  logic [7:0] hold_val  = 8'h00;

  spi_slave_rx_tx #(.DATA_W(DW), .SYNC_STAGES(SS), .UNDERRUN_WORD(UW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid === 1'b1) begin
        rxv_cnt = rxv_cnt + 1;
        rxv_cyc = cyc;
        rxq.push_back(rx_data);
      end
      if (tx_underrun === 1'b1) und_cnt = und_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Position in the word of the i-th bit on the wire
  function automatic int widx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return i;
`else
    return DW - 1 - i;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    tick(1);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    hold_full = 1'b1;
    hold_val  = d;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    tick(4);
    sclk = 1'b0;
    tick(8);
  endtask

  // One word (or partial word); MISO sampled just before each rising edge
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit end_high,
                      input bit do_push, input int push_at, input logic [7:0] pd,
                      output logic [7:0] mi, output logic first);
    mi = 8'h00;
    first = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = mo[widx(i)];
      tick(4);
      mi[widx(i)] = miso;
      if (i == 0) first = miso;
      sclk = 1'b1;
      last_rise_cyc = cyc;
      if (do_push && i == push_at) begin
        tx_valid = 1'b1;
        tx_data  = pd;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tick(3);
      end else begin
        tick(4);
      end
    end
    if (!end_high) sclk = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    tick(3);
    n_checks++; if (miso !== 1'b0) $display("FAIL reset_miso got %b want 0", miso); else n_pass++;
    n_checks++; if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe got %b want 0", miso_oe); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b want 1", tx_ready); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid); else n_pass++;
    n_checks++; if (tx_underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", tx_underrun); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    rst_n = 1'b1;
    tick(4);
    hold_full = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] mi;
    logic       first;
    int         k, rx0, und0;
    rxq.delete();
    rx0 = rxv_cnt; und0 = und_cnt;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL single_ready_pre got %b want 1", tx_ready); else n_pass++;
    push(8'hA5);
    hold_full = 1'b0;
    cs_n = 1'b0;
    k = cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (miso_oe !== 1'b0) $display("FAIL single_oe_early got %b want 0 at +%0d", miso_oe, cyc - k); else n_pass++;
    @(negedge clk);
    n_checks++; if (miso_oe !== 1'b1 || busy !== 1'b1) $display("FAIL single_oe_latency got oe=%b busy=%b want 1,1 at +%0d", miso_oe, busy, cyc - k); else n_pass++;
    n_checks++; if (miso !== 1'b1) $display("FAIL single_first_bit got %b want 1", miso); else n_pass++;
    tick(4);
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL single_ready_after_load got %b want 1", tx_ready); else n_pass++;
    xfer(8'h3C, 8, 1'b1, 1'b0, 0, 8'h00, mi, first);
    cs_high();
    n_checks++; if (mi !== 8'hA5) $display("FAIL single_miso got %h want a5", mi); else n_pass++;
    n_checks++; if (rxv_cnt - rx0 !== 1) $display("FAIL single_rx_pulses got %0d want 1", rxv_cnt - rx0); else n_pass++;
    n_checks++; if (rx_data !== 8'h3C) $display("FAIL single_rx_data got %h want 3c", rx_data); else n_pass++;
    n_checks++; if (rxv_cyc - last_rise_cyc !== SS + 2) $display("FAIL single_rx_latency got %0d want %0d", rxv_cyc - last_rise_cyc, SS + 2); else n_pass++;
    n_checks++; if (und_cnt - und0 !== 0) $display("FAIL single_underrun got %0d want 0", und_cnt - und0); else n_pass++;
    n_checks++; if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) $display("FAIL single_idle got busy=%b oe=%b miso=%b want 0,0,0", busy, miso_oe, miso); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2, mo1, mo2;
    logic       first;
    int         rx0, und0;
    rxq.delete();
    rx0 = rxv_cnt; und0 = und_cnt;
    mo1 = 8'($urandom); mo2 = 8'($urandom);
    push(8'h11);
    cs_low();
    hold_full = 1'b0;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL b2b_ready_mid got %b want 1", tx_ready); else n_pass++;
    xfer(mo1, 8, 1'b0, 1'b1, 3, 8'h22, mi1, first);
    xfer(mo2, 8, 1'b1, 1'b0, 0, 8'h00, mi2, first);
    cs_high();
    n_checks++; if (mi1 !== 8'h11) $display("FAIL b2b_miso_w1 got %h want 11", mi1); else n_pass++;
    n_checks++; if (mi2 !== 8'h22) $display("FAIL b2b_miso_w2 got %h want 22", mi2); else n_pass++;
    n_checks++; if (rxv_cnt - rx0 !== 2) $display("FAIL b2b_rx_pulses got %0d want 2", rxv_cnt - rx0); else n_pass++;
    n_checks++; if (rxq[0] !== mo1 || rxq[1] !== mo2) $display("FAIL b2b_rx_words got %h %h want %h %h", rxq[0], rxq[1], mo1, mo2); else n_pass++;
    n_checks++; if (und_cnt - und0 !== 0) $display("FAIL b2b_underrun got %0d want 0", und_cnt - und0); else n_pass++;
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    logic       first;
    int         und0;
    und0 = und_cnt;
    cs_low();
    xfer(8'hFF, 8, 1'b1, 1'b0, 0, 8'h00, mi, first);
    cs_high();
    n_checks++; if (mi !== UW) $display("FAIL underrun_miso got %h want %h", mi, UW); else n_pass++;
    n_checks++; if (und_cnt - und0 !== 1) $display("FAIL underrun_pulses got %0d want 1", und_cnt - und0); else n_pass++;
    n_checks++; if (rx_data !== 8'hFF) $display("FAIL underrun_rx_data got %h want ff", rx_data); else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] mi, mo, d;
    logic       first;
    int         rx0;
    rxq.delete();
    rx0 = rxv_cnt;
    cs_low();
    xfer(8'($urandom), 5, 1'b1, 1'b0, 0, 8'h00, mi, first);
    cs_high();
    n_checks++; if (rxv_cnt - rx0 !== 0) $display("FAIL abort_rx_pulses got %0d want 0", rxv_cnt - rx0); else n_pass++;
    n_checks++; if (miso_oe !== 1'b0 || busy !== 1'b0) $display("FAIL abort_idle got oe=%b busy=%b want 0,0", miso_oe, busy); else n_pass++;
    mo = 8'($urandom); d = 8'($urandom);
    push(d);
    cs_low();
    hold_full = 1'b0;
    xfer(mo, 8, 1'b1, 1'b0, 0, 8'h00, mi, first);
    cs_high();
    n_checks++; if (mi !== d) $display("FAIL abort_next_miso got %h want %h", mi, d); else n_pass++;
    n_checks++; if (rxq.size() !== 1 || rxq[0] !== mo) $display("FAIL abort_next_rx got n=%0d %h want n=1 %h", rxq.size(), rxq[0], mo); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] mi, mo, pd, et;
    logic       first;
    logic [7:0] exp_rx[$];
    int         nw, pa, und0, exp_und;
    bit         dp;
    for (int f = 0; f < 8; f++) begin
      rxq.delete(); exp_rx.delete();
      und0 = und_cnt; exp_und = 0;
      nw = $urandom_range(1, 3);
      n_checks++; if (tx_ready !== !hold_full) $display("FAIL rand_ready frame %0d got %b want %b", f, tx_ready, !hold_full); else n_pass++;
      if (!hold_full && $urandom_range(0, 1) == 1) push(8'($urandom));
      cs_low();
      for (int w = 0; w < nw; w++) begin
        et = hold_full ? hold_val : UW;
        if (!hold_full) exp_und++;
        hold_full = 1'b0;
        mo = 8'($urandom); pd = 8'($urandom);
        dp = ($urandom_range(0, 1) == 1);
        pa = $urandom_range(1, 6);
        xfer(mo, 8, (w == nw - 1), dp, pa, pd, mi, first);
        if (dp) begin
          hold_full = 1'b1;
          hold_val  = pd;
        end
        exp_rx.push_back(mo);
        n_checks++; if (mi !== et) $display("FAIL rand_miso frame %0d word %0d got %h want %h", f, w, mi, et); else n_pass++;
      end
      cs_high();
      n_checks++; if (rxq.size() !== nw) $display("FAIL rand_rx_count frame %0d got %0d want %0d", f, rxq.size(), nw); else n_pass++;
      for (int w = 0; w < nw; w++) begin
        n_checks++; if (rxq[w] !== exp_rx[w]) $display("FAIL rand_rx frame %0d word %0d got %h want %h", f, w, rxq[w], exp_rx[w]); else n_pass++;
      end
      n_checks++; if (und_cnt - und0 !== exp_und) $display("FAIL rand_underrun frame %0d got %0d want %0d", f, und_cnt - und0, exp_und); else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi, mo, d;
    logic       first;
    if (!hold_full) push(8'h5A);
    cs_low();
    xfer(8'($urandom), 3, 1'b1, 1'b0, 0, 8'h00, mi, first);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0})
      $display("FAIL midreset_outputs got miso=%b oe=%b rdy=%b rx=%h rxv=%b und=%b busy=%b want 0 0 1 00 0 0 0",
               miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy);
    else n_pass++;
    sclk = 1'b0; cs_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    hold_full = 1'b0;
    tick(4);
    rxq.delete();
    mo = 8'($urandom); d = 8'($urandom);
    push(d);
    cs_low();
    hold_full = 1'b0;
    xfer(mo, 8, 1'b1, 1'b0, 0, 8'h00, mi, first);
    cs_high();
    n_checks++; if (mi !== d) $display("FAIL midreset_next_miso got %h want %h", mi, d); else n_pass++;
    n_checks++; if (rxq.size() !== 1 || rxq[0] !== mo) $display("FAIL midreset_next_rx got n=%0d %h want n=1 %h", rxq.size(), rxq[0], mo); else n_pass++;
  endtask

`ifdef SPI_SLAVE_LSB_FIRST_EN
  task automatic test_lsb();
    logic [7:0] mi;
    logic       first;
    push(8'h01);
    cs_low();
    hold_full = 1'b0;
    xfer(8'h80, 8, 1'b1, 1'b0, 0, 8'h00, mi, first);
    cs_high();
    n_checks++; if (first !== 1'b1) $display("FAIL lsb_first_bit got %b want 1", first); else n_pass++;
    n_checks++; if (mi !== 8'h01) $display("FAIL lsb_miso got %h want 01", mi); else n_pass++;
    n_checks++; if (rx_data !== 8'h80) $display("FAIL lsb_rx_data got %h want 80", rx_data); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef SPI_SLAVE_LSB_FIRST_EN
    test_lsb();
`endif
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0), the far end of the SCLK our clock generator drives onto the SPI bus.
- Oversamples SCLK, CS_N and MOSI in the system clock domain and deserialises MOSI into RX_DATA words.
- Serialises TX words onto MISO, with a valid/ready handshake toward local logic.
- Sits between the SPI pins and the local register/data path.

Parameters:
- DATA_W, 8, bits per SPI word.
- SYNC_STAGES, 2, synchroniser flops on SCLK/CS_N/MOSI (minimum 2).
- UNDERRUN_WORD, 0, word shifted out when no TX data is held at word start.

Ports:
- CLK  in  1  system clock; must be ≥ 4x the SCLK frequency.
- RST_N  in  1  asynchronous active-low reset.
- SCLK  in  1  SPI clock from the master (asynchronous).
- CS_N  in  1  SPI chip select, active low (asynchronous).
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- MISO_OE  out  1  MISO output enable (1 while selected).
- TX_DATA  in  DATA_W  word to transmit.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  holding register empty.
- RX_DATA  out  DATA_W  last complete received word.
- RX_VALID  out  1  one-cycle strobe; RX_DATA updated.
- TX_UNDERRUN  out  1  one-cycle strobe; UNDERRUN_WORD was loaded.
- BUSY  out  1  frame in progress.

Behaviour:
- Reset values (async, on RST_N low):
  - MISO=0, MISO_OE=0, TX_READY=1, RX_DATA=0, RX_VALID=0, TX_UNDERRUN=0, BUSY=0.
  - Synchronisers: SCLK stages=0, CS_N stages=1, MOSI stages=0.
  - Bit counter=0, state=IDLE.
- Synchronisers: SCLK/CS_N/MOSI pass through SYNC_STAGES flops. Edge detection compares the last stage with one extra delayed copy (sclk_rise, sclk_fall, cs_fall, cs_rise).
- TX holding register:
  - TX_VALID && TX_READY loads it and TX_READY drops the next cycle.
  - TX_READY returns high the cycle after the holding register is transferred to the shifter.
  - TX_VALID while TX_READY=0 is ignored; TX_DATA is don't-care when TX_VALID=0.
- FSM:
  - IDLE: on cs_fall -> LOAD.
  - LOAD (1 cycle): shifter <= holding if full, else UNDERRUN_WORD with a TX_UNDERRUN pulse. Bit counter <= 0; BUSY=1; MISO_OE=1; MISO=shifter MSB. Then -> SHIFT.
  - SHIFT:
    - sclk_rise: rx_shift <= {rx_shift[DATA_W-2:0], MOSI_sync}; bit counter +1.
    - When the counter reaches DATA_W: RX_DATA <= assembled word, RX_VALID=1 for 1 cycle, counter wraps to 0, and the next sclk_fall performs a LOAD-equivalent reload (back-to-back words, no CS_N toggle needed).
    - Any other sclk_fall: tx_shift shifts left; MISO <= new MSB.
  - Any state, cs_rise: -> IDLE, BUSY=0, MISO_OE=0, MISO=0. Partial word discarded (no RX_VALID); holding register contents kept.
- Latency:
  - MISO first bit valid SYNC_STAGES+2 CLK after the CS_N fall at the pin.
  - RX_VALID SYNC_STAGES+2 CLK after the final SCLK rise at the pin.
- Simultaneous events:
  - TX handshake in the same cycle as a LOAD: the handshake lands in the holding register and is used for the next word; the current LOAD uses the prior contents.
  - cs_rise and sclk_rise in the same cycle: cs_rise wins and the partial word is discarded.
- SCLK edges while CS_N is high are ignored.
- Glitch-free: outputs are registered.

Optional Feature:
- SPI_SLAVE_LSB_FIRST_EN defined: both shifters operate LSB-first. RX shifts right with MOSI entering the MSB; MISO = tx_shift[0], shifting right.
- Undefined: MSB-first as described above.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, LOAD, SHIFT}.
  - DATA_W default constant.
  - UNDERRUN_WORD default constant.
  - Bit counter width localparam = $clog2(DATA_W+1).
- Sub-module spi_sync_edge: SYNC_STAGES-deep synchroniser plus rise/fall detect. Instantiated for SCLK and CS_N; MOSI uses the synchroniser only.

Test Plan:
- Reset check: RST_N pulsed low mid-frame -> all outputs return to reset values immediately; the next frame starts cleanly in IDLE.
- Single word: TX_DATA=0xA5 handshaked; master sends 0x3C at SCLK=CLK/8 -> MISO bits 1,0,1,0,0,1,0,1; RX_DATA=0x3C; one RX_VALID pulse; TX_READY high after LOAD.
- Back-to-back words: two words in one CS_N low period, TX 0x11 then 0x22 (second handshaked during word 1) -> MISO 0x11 then 0x22; RX_VALID pulses twice; no TX_UNDERRUN.
- Underrun: no TX handshake; master sends 0xFF -> MISO shifts 0x00; exactly one TX_UNDERRUN pulse; RX_DATA=0xFF.
- Abort: CS_N deasserted after 5 SCLK rises -> no RX_VALID, MISO_OE=0, BUSY=0. The next full frame receives correctly from bit 0.
- LSB-first build (SPI_SLAVE_LSB_FIRST_EN): TX 0x01, RX stream 0x80 -> MISO first bit=1; RX_DATA=0x80 with bit order reversed on the wire.
